// File: rtl/jt1943_scr_fetch_pkg.sv
// Shared constants for the 1943 scroll ROM fetch stage: address widths and arbiter states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: MAP_AW / GFX_AW / SDRAM_AW widths, fetch_st_t arbiter state encoding,
// rom_addr() helper that forms a wrapped SDRAM word address from a client address and offset.
package jt1943_scr_fetch_pkg;

    localparam int MAP_AW   = 14;
    localparam int GFX_AW   = 17;
    localparam int SDRAM_AW = 22;
    localparam int ROM_DW   = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_MAP  = 3'd1,
        ST_WAIT_MAP = 3'd2,
        ST_REQ_GFX  = 3'd3,
        ST_WAIT_GFX = 3'd4
    } fetch_st_t;

    // SDRAM word address arithmetic wraps modulo 2^SDRAM_AW by construction.
    function automatic logic [SDRAM_AW-1:0] rom_addr(
        input logic [SDRAM_AW-1:0] addr,
        input logic [SDRAM_AW-1:0] offset
    );
        return addr + offset;
    endfunction

endpackage

// File: rtl/jt1943_fetch_port.sv
// One-entry address/data latch for a single ROM client port; flags whether the client address needs a fetch.
// Latency: write lands one edge after wr_en_i; ok_o/pending_o are combinational on the current client address.
// Backpressure: none; the arbiter decides when to fill, the client simply watches ok_o.
//
// Ports: clk, rst_n (sync, active-low); addr_i current client address; wr_en_i/wr_tag_i/wr_dat_i fill
// from the arbiter; pending_o = needs fetch; ok_o = dat_o belongs to addr_i; dat_o last fetched word.
module jt1943_fetch_port #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_tag_i,
    input  logic [DW-1:0] wr_dat_i,
    output logic          pending_o,
    output logic          ok_o,
    output logic [DW-1:0] dat_o
);

    logic [AW-1:0] last_addr_q;
    logic          valid_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_addr_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else if (wr_en_i) begin
            // The tag is the address captured when the fetch was issued, not the
            // live client address, so a mid-flight change leaves ok_o low.
            last_addr_q <= wr_tag_i;
            valid_q     <= 1'b1;
            data_q      <= wr_dat_i;
        end
    end

    // Combinational on purpose: ok must drop in the same cycle the client moves.
    assign ok_o      = valid_q && (addr_i == last_addr_q);
    assign pending_o = !ok_o;
    assign dat_o     = data_q;

endmodule

// File: rtl/jt1943_scr_fetch.sv
// ROM fetch stage for the 1943 scroll layer: serves tile-map and tile-gfx ports from one shared SDRAM slot.
// Latency: request rises the edge after a miss is seen in IDLE; data/ok update the edge after sdram_dok; hits cost zero cycles.
// Backpressure: sdram_req held until sdram_ack; clients stall by watching map_ok/scr_ok; gfx wins over map.
//
// Ports: clk, rst_n (sync, active-low); map_addr -> map_data/map_ok; scr_addr -> scrom_data/scr_ok;
// SDRAM side: sdram_req/sdram_addr out, sdram_ack/sdram_dok/sdram_data in.
module jt1943_scr_fetch
    import jt1943_scr_fetch_pkg::*;
#(
    parameter logic [SDRAM_AW-1:0] MAP_OFFSET = 22'h0,
    parameter logic [SDRAM_AW-1:0] GFX_OFFSET = 22'h10000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MAP_AW-1:0]   map_addr,
    output logic [ROM_DW-1:0]   map_data,
    output logic                map_ok,
    input  logic [GFX_AW-1:0]   scr_addr,
    output logic [ROM_DW-1:0]   scrom_data,
    output logic                scr_ok,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                sdram_dok,
    input  logic [ROM_DW-1:0]   sdram_data
);

    fetch_st_t             state_q;
    logic                  req_q;
    logic [SDRAM_AW-1:0]   addr_q;
    // Wide enough for either port; map uses the low MAP_AW bits.
    logic [GFX_AW-1:0]     tag_q;

    logic map_pending;
    logic gfx_pending;
    logic map_wr;
    logic gfx_wr;

    // Data is only accepted in the matching WAIT state, so stray dok pulses are dropped.
    assign map_wr = (state_q == ST_WAIT_MAP) && sdram_dok;
    assign gfx_wr = (state_q == ST_WAIT_GFX) && sdram_dok;

    jt1943_fetch_port #(
        .AW (MAP_AW),
        .DW (ROM_DW)
    ) u_map_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_i    (map_addr),
        .wr_en_i   (map_wr),
        .wr_tag_i  (tag_q[MAP_AW-1:0]),
        .wr_dat_i  (sdram_data),
        .pending_o (map_pending),
        .ok_o      (map_ok),
        .dat_o     (map_data)
    );

    jt1943_fetch_port #(
        .AW (GFX_AW),
        .DW (ROM_DW)
    ) u_gfx_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_i    (scr_addr),
        .wr_en_i   (gfx_wr),
        .wr_tag_i  (tag_q),
        .wr_dat_i  (sdram_data),
        .pending_o (gfx_pending),
        .ok_o      (scr_ok),
        .dat_o     (scrom_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            tag_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Gfx first: its deadline is half that of the map.
                    if (gfx_pending) begin
                        addr_q  <= rom_addr(SDRAM_AW'(scr_addr), GFX_OFFSET);
                        tag_q   <= scr_addr;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ_GFX;
                    end else if (map_pending) begin
                        addr_q  <= rom_addr(SDRAM_AW'(map_addr), MAP_OFFSET);
                        tag_q   <= GFX_AW'(map_addr);
                        req_q   <= 1'b1;
                        state_q <= ST_REQ_MAP;
                    end
                end
                ST_REQ_MAP: begin
                    if (sdram_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT_MAP;
                    end
                end
                ST_REQ_GFX: begin
                    if (sdram_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT_GFX;
                    end
                end
                ST_WAIT_MAP, ST_WAIT_GFX: begin
                    // Never cancelled: the port latch takes the captured tag.
                    if (sdram_dok) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

endmodule

// File: tb/tb_jt1943_scr_fetch.sv
// Self-checking bench for jt1943_scr_fetch: random SDRAM responder, reference cache model and scoreboard.
// Latency: n/a.
// Backpressure: responder inserts random ack/dok delays and stray pulses.
module tb_jt1943_scr_fetch;

    localparam logic [21:0] MAP_OFF = 22'h0;
    localparam logic [21:0] GFX_OFF = 22'h010000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [13:0] map_addr;
    logic [16:0] scr_addr;
    logic [15:0] map_data, scrom_data;
    logic        map_ok, scr_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        sdram_dok = 1'b0;
    logic [15:0] sdram_data = 16'h0;

    logic [15:0] w_map_data, w_scrom_data;
    logic        w_map_ok, w_scr_ok, w_req;
    logic [21:0] w_addr;

    jt1943_scr_fetch #(.MAP_OFFSET(MAP_OFF), .GFX_OFFSET(GFX_OFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .map_addr(map_addr), .map_data(map_data), .map_ok(map_ok),
        .scr_addr(scr_addr), .scrom_data(scrom_data), .scr_ok(scr_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .sdram_data(sdram_data)
    );

    // Second instance only exercises offset wrap-around; its SDRAM never answers.
    jt1943_scr_fetch #(.MAP_OFFSET(22'h0), .GFX_OFFSET(22'h3FFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .map_addr(14'h0), .map_data(w_map_data), .map_ok(w_map_ok),
        .scr_addr(17'h00002), .scrom_data(w_scrom_data), .scr_ok(w_scr_ok),
        .sdram_req(w_req), .sdram_addr(w_addr),
        .sdram_ack(1'b0), .sdram_dok(1'b0), .sdram_data(16'h0)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // SDRAM contents: one fixed word plus a hash of the address everywhere else.
    function automatic logic [15:0] memf(input logic [21:0] a);
        if (a == 22'h000123) return 16'hBEEF;
        return a[15:0] ^ {a[21:16], a[9:0]} ^ 16'h5A5A;
    endfunction

    // ---------------- SDRAM responder (drives on negedge) ----------------
    int          r_phase = 0;
    int          r_cnt = 0;
    logic [21:0] r_addr = 22'h0;
    logic        dok_real = 1'b0;
    logic        late_dok = 1'b0;
    bit          slow = 1'b0;

    always @(negedge clk) begin
        sdram_ack  = 1'b0;
        sdram_dok  = 1'b0;
        dok_real   = 1'b0;
        sdram_data = 16'($urandom);
        if (!rst_n) begin
            if (r_phase == 2) late_dok = 1'b1;
            r_phase   = 0;
            sdram_dok = ($urandom % 2) == 1;
        end else if (late_dok) begin
            late_dok  = 1'b0;
            sdram_dok = 1'b1;
        end else if (r_phase == 2) begin
            if (r_cnt == 0) begin
                sdram_dok  = 1'b1;
                dok_real   = 1'b1;
                sdram_data = memf(r_addr);
                r_phase    = 0;
            end else begin
                r_cnt--;
                sdram_ack = ($urandom % 4) == 0;
            end
        end else if (r_phase == 1) begin
            if (r_cnt == 0) begin
                sdram_ack = 1'b1;
                r_phase   = 2;
                r_cnt     = slow ? 8 : int'($urandom_range(0, 4));
            end else begin
                r_cnt--;
                sdram_dok = ($urandom % 4) == 0;
            end
        end else begin
            if (sdram_req) begin
                r_addr  = sdram_addr;
                r_phase = 1;
                r_cnt   = int'($urandom_range(0, 3));
            end else begin
                sdram_dok = ($urandom % 6) == 0;
            end
        end
    end

    // ---------------- reference model + scoreboard monitor ----------------
    typedef struct {
        bit          gfx;
        logic [16:0] tag;
        logic [21:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    logic [21:0] issue_log[$];
    int          issue_cnt = 0;

    bit          mv_map = 0, mv_gfx = 0;
    logic [13:0] ml_map = '0;
    logic [16:0] ml_gfx = '0;
    bit          busy = 0, acked = 0;
    logic [21:0] held_addr = '0;
    bit          gp, mp;
    exp_t        e;

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            check("rst_req", sdram_req, 0);
            check("rst_addr", sdram_addr, 0);
            check("rst_map_ok", map_ok, 0);
            check("rst_scr_ok", scr_ok, 0);
            check("rst_map_data", map_data, 0);
            check("rst_scr_data", scrom_data, 0);
            mv_map = 0; mv_gfx = 0; ml_map = '0; ml_gfx = '0;
            busy = 0; acked = 0;
            sb_q.delete();
        end else begin
            if (!busy) begin
                gp = !mv_gfx || (scr_addr != ml_gfx);
                mp = !mv_map || (map_addr != ml_map);
                check("req_issue", sdram_req, gp || mp);
                if (sdram_req) begin
                    e.gfx  = gp;
                    e.tag  = gp ? scr_addr : 17'(map_addr);
                    e.addr = gp ? (22'(scr_addr) + GFX_OFF) : (22'(map_addr) + MAP_OFF);
                    check("req_addr", sdram_addr, e.addr);
                    sb_q.push_back(e);
                    busy = 1; acked = 0;
                    held_addr = sdram_addr;
                    issue_cnt++;
                    issue_log.push_back(sdram_addr);
                end
            end else if (!acked) begin
                if (sdram_ack) begin
                    check("req_drop", sdram_req, 0);
                    acked = 1;
                end else begin
                    check("req_hold", sdram_req, 1);
                    check("addr_stable", sdram_addr, held_addr);
                end
            end else begin
                check("req_low_wait", sdram_req, 0);
                if (sdram_dok && dok_real) begin
                    check("sb_depth", sb_q.size(), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        if (e.gfx) begin
                            mv_gfx = 1; ml_gfx = e.tag;
                            check("gfx_fill", scrom_data, memf(e.addr));
                        end else begin
                            mv_map = 1; ml_map = e.tag[13:0];
                            check("map_fill", map_data, memf(e.addr));
                        end
                    end
                    busy = 0;
                end
            end
            check("map_ok", map_ok, mv_map && (map_addr == ml_map));
            check("scr_ok", scr_ok, mv_gfx && (scr_addr == ml_gfx));
            check("map_data", map_data, mv_map ? memf(22'(ml_map) + MAP_OFF) : 16'h0);
            check("scr_data", scrom_data, mv_gfx ? memf(22'(ml_gfx) + GFX_OFF) : 16'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ok(input bit gfx, input int maxc, input string name);
        bit got = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            step();
            got = gfx ? scr_ok : map_ok;
        end
        check(name, got, 1);
    endtask

    task automatic wait_phase2(input int maxc, input string name);
        bit got = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            step();
            got = (r_phase == 2);
        end
        check(name, got, 1);
    endtask

    logic [13:0] mpool[8];
    logic [16:0] gpool[8];
    int          n0;
    bit          got_w;

    initial begin
        rst_n    = 1'b0;
        map_addr = 14'h0;
        scr_addr = 17'h0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;

        // Wrap-around instance: 2 + 0x3FFFFF mod 2^22 = 1.
        got_w = 0;
        for (int i = 0; i < 6 && !got_w; i++) begin
            step();
            got_w = w_req;
        end
        check("wrap_req", got_w, 1);
        check("wrap_addr", w_addr, 22'h000001);

        wait_ok(1, 80, "init_gfx_timeout");
        wait_ok(0, 80, "init_map_timeout");

        // Single map miss, then hold (no traffic on hit).
        n0 = issue_cnt;
        map_addr = 14'h0123;
        wait_ok(0, 60, "map_miss_timeout");
        check("map_miss_data", map_data, 16'hBEEF);
        check("map_miss_n", issue_cnt - n0, 1);
        if (issue_log.size() > n0) check("map_miss_addr", issue_log[n0], 22'h000123);
        repeat (20) step();
        check("hold_no_req", issue_cnt - n0, 1);

        // Collision: gfx must be served before map.
        n0 = issue_cnt;
        map_addr = 14'h0456;
        scr_addr = 17'h1ABCD;
        wait_ok(0, 120, "coll_timeout");
        check("coll_scr_first", scr_ok, 1);
        check("coll_n", issue_cnt - n0, 2);
        if (issue_log.size() > n0 + 1) begin
            check("coll_first", issue_log[n0], 22'h02ABCD);
            check("coll_second", issue_log[n0 + 1], 22'h000456);
        end

        // Address change after ack, before dok: fetch completes, then refetch.
        n0 = issue_cnt;
        scr_addr = 17'h00010;
        wait_phase2(30, "mid_ack_timeout");
        step();
        scr_addr = 17'h00011;
        wait_ok(1, 80, "mid_timeout");
        check("mid_n", issue_cnt - n0, 2);
        if (issue_log.size() > n0 + 1) begin
            check("mid_first", issue_log[n0], 22'h010010);
            check("mid_second", issue_log[n0 + 1], 22'h010011);
        end

        // Reset while waiting for gfx data; a late dok follows the release.
        slow = 1'b1;
        scr_addr = 17'h00020;
        wait_phase2(30, "rst_ack_timeout");
        step();
        step();
        rst_n = 1'b0;
        step();
        step();
        slow = 1'b0;
        n0 = issue_cnt;
        rst_n = 1'b1;
        step();
        check("rst_mid_scr_ok", scr_ok, 0);
        check("rst_mid_map_ok", map_ok, 0);
        wait_ok(1, 80, "rst_gfx_timeout");
        wait_ok(0, 80, "rst_map_timeout");
        if (issue_log.size() > n0) check("rst_reissue", issue_log[n0], 22'h010020);

        // Random traffic with small address pools to mix hits and misses.
        foreach (mpool[i]) mpool[i] = 14'($urandom);
        foreach (gpool[i]) gpool[i] = 17'($urandom);
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom % 10 == 0) map_addr = mpool[$urandom % 8];
            if ($urandom % 20 == 0) scr_addr = gpool[$urandom % 8];
            if ($urandom % 900 == 0) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
        end
        wait_ok(1, 80, "final_gfx_timeout");
        wait_ok(0, 80, "final_map_timeout");
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jt1943_scr_fetch.md
# jt1943_scr_fetch

ROM fetch stage directly upstream of the 1943 scroll tile generator. Serves its two ROM ports, 14-bit tile-map address and 17-bit tile-graphics address, from one shared SDRAM slot. Keeps a one-entry address/data latch per port and only issues SDRAM reads on address change. Gfx reads take priority over map reads, because the graphics deadline is 4 pixels and the map deadline is 8.

## Interface
Parameters:
- MAP_OFFSET, 22'h0, SDRAM word offset added to map address
- GFX_OFFSET, 22'h10000, SDRAM word offset added to gfx address

Ports:
- clk  in  1  system clock (>12 MHz); the only clock
- rst_n  in  1  reset; synchronous, active-low
- map_addr  in  14  tile-map word address from scroll block
- map_data  out  16  map word for the last completed map_addr
- map_ok  out  1  high when map_data matches current map_addr
- scr_addr  in  17  graphics word address from scroll block
- scrom_data  out  16  graphics word for the last completed scr_addr
- scr_ok  out  1  high when scrom_data matches current scr_addr
- sdram_req  out  1  read request; held until sdram_ack
- sdram_addr  out  22  word address; stable while sdram_req high
- sdram_ack  in  1  request accepted (one-cycle pulse)
- sdram_dok  in  1  sdram_data valid (one-cycle pulse, after ack)
- sdram_data  in  16  read data

## Operation
- Per port registers: last_addr, valid flag, data. A port is pending when `!valid || addr != last_addr`.
- ok = valid && (addr == last_addr). The check is combinational on the registered fields, so ok drops in the same cycle the address changes.
- FSM states:
  - IDLE:
    - If gfx is pending: sdram_addr = scr_addr + GFX_OFFSET (zero-extended), capture tag = scr_addr, go to REQ_GFX.
    - Else if map is pending: sdram_addr = map_addr + MAP_OFFSET, capture tag = map_addr, go to REQ_MAP.
  - REQ_x: sdram_req = 1. On sdram_ack, go to WAIT_x.
  - WAIT_x: on sdram_dok, write data and last_addr = captured tag for port x, set valid, return to IDLE.
- Address changes while a fetch is in flight:
  - The fetch completes and is written with its captured tag.
  - ok stays low because addr != tag, so the port re-enters pending on the next IDLE.
  - No request is ever cancelled.
- Tag register is captured in IDLE. Client address changes do not alter sdram_addr while sdram_req is high.
- sdram_dok while in IDLE or REQ_x is ignored and not counted. sdram_ack outside REQ_x is ignored.
- Address arithmetic is modulo 2^22; overflow wraps silently.
- Reset values (rst_n low at a clk edge):
  - FSM = IDLE, sdram_req = 0, sdram_addr = 0
  - both valid = 0, map_ok = 0, scr_ok = 0
  - map_data = 0, scrom_data = 0, last_addr = 0
- Reset mid-fetch abandons the transaction. The SDRAM controller must be reset by the same rst_n.

## Timing
- Request issue: port pending in IDLE at edge n → sdram_req high from edge n+1.
- sdram_req falls on the edge after the sdram_ack cycle.
- Data: sdram_dok at edge m → data, valid and ok updated at edge m+1. Data goes straight from register to output, with no extra output stage.
- Back-to-back fetches: IDLE costs one cycle, so the next sdram_req rises at m+2.
- Hit (address unchanged): zero cycles, no SDRAM traffic.
- Both ports pending: gfx served first. Map waits at most one full gfx transaction.
- Budget: one gfx and one map transaction must both fit in 8 cen6 periods. The SDRAM slot latency is bounded by the top level, not checked here.

## Structure
- Constants for the shared jt1943 package: FSM state encoding (IDLE, REQ_MAP, WAIT_MAP, REQ_GFX, WAIT_GFX), MAP_AW = 14, GFX_AW = 17, SDRAM_AW = 22.
- One sub-module, jt1943_fetch_port, instantiated twice with an address width parameter. It holds last_addr, valid and data, and produces the pending and ok signals.
- The arbiter FSM lives in the top module.

## Test plan
- Reset/idle: hold rst_n low 4 cycles with sdram_dok pulsing → sdram_req = 0, map_ok = 0, scr_ok = 0, both data = 0.
- Single map miss: map_addr = 14'h0123, MAP_OFFSET = 0 → sdram_addr = 22'h000123. Ack, then dok with 16'hBEEF → map_data = BEEF, map_ok = 1 one edge after dok. Holding the address issues no new sdram_req.
- Collision: map_addr and scr_addr change in the same cycle (scr_addr = 17'h1ABCD, GFX_OFFSET = 22'h10000) → first sdram_addr = 22'h02ABCD (gfx), second = map; scr_ok rises before map_ok.
- Mid-flight change: scr_addr 17'h00010 → 17'h00011 after ack, before dok → first data stored, scr_ok stays 0, then a second request to 22'h010011; scr_ok = 1 only after its dok.
- Reset mid-operation: rst_n low during WAIT_GFX, then a late dok arrives after release → FSM is IDLE, valid = 0, late dok ignored, fresh request reissued for the current addresses.
- Wrap: GFX_OFFSET = 22'h3FFFFF, scr_addr = 17'h00002 → sdram_addr = 22'h000001.
